alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Iterative multiply/divide unit beside the single-cycle ALU in the EX stage. Executes
//  MULT/MULTU/DIV/DIVU on WIDTH-bit operands over multiple cycles and holds results in
//  internal HI/LO registers, which MFHI/MFLO read. Also supports MTHI/MTLO writes.
//  The pipeline control stalls on busy and continues on done.
// PARAMETERS
//  WIDTH   32   operand and HI/LO width (>=4); one iteration per operand bit
// PORTS
//  clock      in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high
//  start      in   1      request; sampled only while busy=0
//  op         in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV (from Function_opcode[1:0])
//  Read_data_1 in  WIDTH  operand A (multiplicand / dividend)
//  Read_data_2 in  WIDTH  operand B (multiplier / divisor)
//  cancel     in   1      abort an in-flight op (exception/flush)
//  hi_we      in   1      MTHI: HI <= Read_data_1 (only while busy=0)
//  lo_we      in   1      MTLO: LO <= Read_data_1 (only while busy=0)
//  busy       out  1      operation in flight
//  done       out  1      one-cycle pulse: HI/LO updated at this same edge
//  div_zero   out  1      sticky per op: last DIV/DIVU had B==0
//  HI         out  WIDTH  high product / remainder
//  LO         out  WIDTH  low product / quotient
// BEHAVIOUR
//  Reset (async): state=IDLE. busy=0, done=0, div_zero=0, HI=0, LO=0, counter=0.
//  FSM: IDLE -> CALC (start & !busy) -> FIX (counter hits WIDTH) -> IDLE.
//   IDLE: latch op and |A|,|B| (signed ops: magnitude and result signs). Set busy=1.
//     Clear div_zero. Load counter=0.
//   CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//     Runs WIDTH cycles. Uses 2*WIDTH accumulator. Divisor subtract is WIDTH+1 bits wide.
//   FIX: apply signs and write HI/LO. Pulse done=1. Drop busy=0. Return to IDLE.
//  Latency: start at edge k -> HI/LO/done updated at edge k+WIDTH+1. Constant for every op,
//   including divide-by-zero. busy high from edge k to edge k+WIDTH+1.
//  Mul: {HI,LO} = A*B. MULT takes the product sign as signA^signB, 2*WIDTH-bit two's complement.
//  Div: LO = quotient truncated toward zero. HI = remainder, with the sign of the dividend.
//  DIV of MIN/-1: LO=MIN, HI=0. No trap.
//  B==0 on DIVU/DIV: div_zero=1 at the done edge. HI=A (unsigned raw), LO=all ones.
//   Latency unchanged.
//  start while busy=1: ignored, no queueing. hi_we/lo_we while busy=1: ignored.
//  start and hi_we/lo_we on the same idle edge: the write takes effect, and the op starts.
//   The op result overwrites HI/LO at completion.
//  cancel while busy: at the next edge, go to IDLE with busy=0 and done=0.
//   HI/LO keep their pre-op values. cancel while idle has no effect.
//   cancel has priority over the FIX write.
//  Async reset mid-op: immediate return to reset values. No done pulse.
// TESTING (WIDTH=32)
//  MULTU FFFFFFFF*FFFFFFFF -> done at edge k+33. HI=FFFFFFFE, LO=00000001.
//   busy high for exactly 33 cycles.
//  MULT -3*5 -> HI=FFFFFFFF, LO=FFFFFFF1. MULT 80000000*80000000 -> HI=40000000, LO=0.
//  DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
//   DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  DIVU 00000064/0 -> after 33 cycles: div_zero=1, HI=00000064, LO=FFFFFFFF.
//   The next valid op clears div_zero.
//  cancel at cycle 10 of MULTU 5*6 with HI=LO=AAAAAAAA -> busy=0 next edge, no done,
//   HI/LO=AAAAAAAA. A second start at cycle 5 of an op is ignored.
//  MTLO 1234 while idle -> LO=1234. MTHI while busy -> HI unchanged.
//  reset pulse at cycle 20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_muldiv_if                                              |
// | Description : Request/result bundle between EX-stage control and the     |
// |               iterative multiply/divide unit.                            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, Read_data_1, Read_data_2, cancel, hi_we, lo_we,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, op, Read_data_1, Read_data_2, cancel, hi_we, lo_we,
    output busy, done, div_zero, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_muldiv                                                 |
// | Description : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers,   |
// |               one shift-add / restoring-divide step per cycle.           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input wire          clock,
  input wire          reset,
  alu_muldiv_if.slave bus
);

  localparam int                c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_is_div;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic                 r_b_zero;
  logic                 r_done;
  logic                 r_div_zero;
  logic [WIDTH-1:0]     r_mag_a;
  logic [WIDTH-1:0]     r_mag_b;
  logic [WIDTH-1:0]     r_a_raw;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_acc;

  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_hi_fix;
  logic [WIDTH-1:0]     w_lo_fix;

  // Operand magnitudes; op[0] marks the signed variants.
  always_comb begin
    w_mag_a = bus.Read_data_1;
    w_mag_b = bus.Read_data_2;
    if (bus.op[0] && bus.Read_data_1[WIDTH-1]) w_mag_a = -bus.Read_data_1;
    if (bus.op[0] && bus.Read_data_2[WIDTH-1]) w_mag_b = -bus.Read_data_2;
  end

  // Mul: low half holds the multiplier, consumed LSB first.
  // Div: partial remainder in the high half, quotient bits shift into the low half.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mag_b};
    if (r_is_div) begin
      if (w_trial[WIDTH])
        w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
      else
        w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod = r_acc;
    w_quot = r_acc[WIDTH-1:0];
    w_rem  = r_acc[2*WIDTH-1:WIDTH];
    if (r_sign_a ^ r_sign_b) begin
      w_prod = -r_acc;
      w_quot = -r_acc[WIDTH-1:0];
    end
    if (r_sign_a) w_rem = -r_acc[2*WIDTH-1:WIDTH];

    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_hi_fix = r_a_raw;
        w_lo_fix = '1;
      end else begin
        w_hi_fix = w_rem;
        w_lo_fix = w_quot;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_CALC;
      S_CALC: begin
        if (bus.cancel)             w_next = S_IDLE;
        else if (r_count == c_last) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_b_zero   <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_a_raw    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.hi_we) r_hi <= bus.Read_data_1;
          if (bus.lo_we) r_lo <= bus.Read_data_1;
          if (bus.start) begin
            r_is_div   <= bus.op[1];
            r_sign_a   <= bus.op[0] & bus.Read_data_1[WIDTH-1];
            r_sign_b   <= bus.op[0] & bus.Read_data_2[WIDTH-1];
            r_b_zero   <= (bus.Read_data_2 == '0);
            r_mag_a    <= w_mag_a;
            r_mag_b    <= w_mag_b;
            r_a_raw    <= bus.Read_data_1;
            r_div_zero <= 1'b0;
            r_count    <= '0;
            r_acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
          end
        end
        S_CALC: begin
          if (!bus.cancel) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + c_cnt_w'(1);
          end
        end
        S_FIX: begin
          // A flush arriving on the final cycle still wins over the write-back.
          if (!bus.cancel) begin
            r_hi       <= w_hi_fix;
            r_lo       <= w_lo_fix;
            r_done     <= 1'b1;
            r_div_zero <= r_is_div & r_b_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_muldiv                                              |
// | Description : Self-checking bench: directed table, hand corner cases and |
// |               random ops against an arithmetic reference model.          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_alu_muldiv;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin
        if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
        else begin
          q = sa / sb; r = sa % sb;
          p = q; lo = p[31:0];
          p = r; hi = p[31:0];
        end
      end
    endcase
  endtask

  task automatic wait_done(input int already, output int lat, output bit busy_ok);
    lat     = already;
    busy_ok = 1'b1;
    while (!bus.done && lat < W + 10) begin
      @(posedge clock); #1;
      lat++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input string tag);
    int lat;
    bit busy_ok;
    @(negedge clock);
    bus.start = 1'b1; bus.op = op; bus.Read_data_1 = a; bus.Read_data_2 = b;
    @(posedge clock); #1;
    check({tag, ".busy_start"}, W'(bus.busy), W'(1));
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(0, lat, busy_ok);
    check({tag, ".latency"}, W'(lat), W'(W + 1));
    check({tag, ".busy_during"}, W'(busy_ok), W'(1));
    check({tag, ".busy_at_done"}, W'(bus.busy), W'(0));
    check({tag, ".hi"}, bus.HI, ehi);
    check({tag, ".lo"}, bus.LO, elo);
    check({tag, ".div_zero"}, W'(bus.div_zero), W'(edz));
    @(posedge clock); #1;
    check({tag, ".done_pulse"}, W'(bus.done), W'(0));
    n_vec++;
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit saw_done;
    logic [1:0]   op;
    logic [W-1:0] a, b, ehi, elo;
    logic         edz;

    tbl[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    tbl[2]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[3]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[4]  = '{2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    tbl[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[6]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    tbl[7]  = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[8]  = '{2'b11, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
    tbl[9]  = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
    tbl[10] = '{2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};
    tbl[11] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};

    bus.start = 0; bus.op = 0; bus.Read_data_1 = 0; bus.Read_data_2 = 0;
    bus.cancel = 0; bus.hi_we = 0; bus.lo_we = 0;
    reset = 1'b1;
    #23;
    check("reset.busy", W'(bus.busy), W'(0));
    check("reset.done", W'(bus.done), W'(0));
    check("reset.div_zero", W'(bus.div_zero), W'(0));
    check("reset.hi", bus.HI, '0);
    check("reset.lo", bus.LO, '0);
    @(negedge clock); reset = 1'b0;

    // MTLO while idle
    @(negedge clock); bus.lo_we = 1; bus.Read_data_1 = 32'h0000_1234;
    @(posedge clock); #1;
    check("mtlo.lo", bus.LO, 32'h0000_1234);
    check("mtlo.hi", bus.HI, '0);
    @(negedge clock); bus.lo_we = 0;

    // Cancel at cycle 10 of MULTU 5*6, HI/LO preloaded with AAAAAAAA
    bus.hi_we = 1; bus.lo_we = 1; bus.Read_data_1 = 32'hAAAA_AAAA;
    @(negedge clock);
    bus.hi_we = 0; bus.lo_we = 0;
    bus.start = 1; bus.op = 2'b00; bus.Read_data_1 = 5; bus.Read_data_2 = 6;
    @(posedge clock); #1;
    @(negedge clock); bus.start = 0;
    repeat (9) @(posedge clock);
    @(negedge clock); bus.cancel = 1;
    @(posedge clock); #1;
    check("cancel.busy", W'(bus.busy), W'(0));
    check("cancel.done", W'(bus.done), W'(0));
    @(negedge clock); bus.cancel = 0;
    saw_done = 0;
    repeat (30) begin @(posedge clock); #1; if (bus.done) saw_done = 1; end
    check("cancel.no_done", W'(saw_done), W'(0));
    check("cancel.hi", bus.HI, 32'hAAAA_AAAA);
    check("cancel.lo", bus.LO, 32'hAAAA_AAAA);
    n_vec++;

    // Second start and MTHI at cycle 5 of MULTU 3*4 are both ignored
    @(negedge clock);
    bus.start = 1; bus.op = 2'b00; bus.Read_data_1 = 3; bus.Read_data_2 = 4;
    @(posedge clock); #1;
    @(negedge clock); bus.start = 0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    bus.start = 1; bus.op = 2'b10; bus.Read_data_1 = 32'hDEAD_BEEF; bus.Read_data_2 = 7;
    bus.hi_we = 1;
    @(posedge clock); #1;
    check("busy_wr.hi", bus.HI, 32'hAAAA_AAAA);
    @(negedge clock); bus.start = 0; bus.hi_we = 0;
    wait_done(5, lat, busy_ok);
    check("restart.latency", W'(lat), W'(W + 1));
    check("restart.hi", bus.HI, 32'h0);
    check("restart.lo", bus.LO, 32'hC);
    @(posedge clock); #1;
    check("restart.idle", W'(bus.busy), W'(0));
    n_vec++;

    // MTLO on the same edge as start: write lands, result overwrites later
    @(negedge clock);
    bus.start = 1; bus.lo_we = 1; bus.op = 2'b00;
    bus.Read_data_1 = 32'h0000_1111; bus.Read_data_2 = 3;
    @(posedge clock); #1;
    check("start_wr.lo", bus.LO, 32'h0000_1111);
    @(negedge clock); bus.start = 0; bus.lo_we = 0;
    wait_done(0, lat, busy_ok);
    check("start_wr.latency", W'(lat), W'(W + 1));
    check("start_wr.result", bus.LO, 32'h0000_3333);
    n_vec++;

    // Async reset at cycle 20 of an op
    @(negedge clock); bus.hi_we = 1; bus.Read_data_1 = 32'h5A5A_5A5A;
    @(negedge clock); bus.hi_we = 0;
    bus.start = 1; bus.op = 2'b00; bus.Read_data_1 = 32'hFFFF_FFFF; bus.Read_data_2 = 2;
    @(posedge clock); #1;
    @(negedge clock); bus.start = 0;
    repeat (20) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.busy", W'(bus.busy), W'(0));
    check("rst_mid.done", W'(bus.done), W'(0));
    check("rst_mid.hi", bus.HI, '0);
    check("rst_mid.lo", bus.LO, '0);
    @(negedge clock); reset = 1'b0;
    saw_done = 0;
    repeat (W + 5) begin @(posedge clock); #1; if (bus.done || bus.busy) saw_done = 1; end
    check("rst_mid.quiet", W'(saw_done), W'(0));
    n_vec++;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz,
             $sformatf("tbl%0d", i));

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      ref_model(op, a, b, ehi, elo, edz);
      run_op(op, a, b, ehi, elo, edz, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
